// File: rtl/fetch_inst_buffer_pkg.sv
// Shared backend definitions: fetch entry payload, fetch width, buffer depth
// default and a popcount helper for contiguous valid masks.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package fetch_inst_buffer_pkg;

  localparam int unsigned FETCH_WIDTH = `FETCH_WIDTH;
  localparam int unsigned FIB_DEPTH   = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
  } fetchEntry_t;

  function automatic int unsigned popcount(input logic [FETCH_WIDTH-1:0] mask);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// Circular instruction queue between fetch and the backend. Defining
// FETCH_INST_BUFFER_BYPASS_EN enables zero-latency delivery into an empty buffer.
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = FIB_DEPTH,
  parameter int unsigned FETCH_WIDTH = `FETCH_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_fetch_vld,
  input  logic [$clog2(FETCH_WIDTH):0]          i_fetch_cnt,
  input  fetchEntry_t [FETCH_WIDTH-1:0]         i_fetch_inst,
  output logic                                  o_fetch_ready,
  output logic [FETCH_WIDTH-1:0]                o_inst_vld,
  output fetchEntry_t [FETCH_WIDTH-1:0]         o_inst,
  input  logic                                  i_stall,
  input  logic                                  i_squash_vld
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(FETCH_WIDTH) + 1;

  fetchEntry_t                   mem [DEPTH];
  logic [PW-1:0]                 wptr;
  logic [PW-1:0]                 rptr;
  logic [PW-1:0]                 count;
  logic [PW-1:0]                 free_slots;
  logic [FETCH_WIDTH-1:0]        arr_vld;
  fetchEntry_t [FETCH_WIDTH-1:0] arr_inst;
  logic                          enq;
  logic                          deq;
  logic                          wr_en;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count         = wptr - rptr;
  assign free_slots    = PW'(DEPTH) - count;
  assign o_fetch_ready = free_slots >= PW'(FETCH_WIDTH);
  assign enq           = i_fetch_vld && o_fetch_ready && !i_squash_vld;
  assign deq           = !i_stall && !i_squash_vld;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_rd
    localparam logic [AW-1:0] OFS = AW'(k);
    localparam logic [PW-1:0] KP  = PW'(k);
    assign arr_inst[k] = mem[rptr[AW-1:0] + OFS];
    assign arr_vld[k]  = count > KP;
  end

`ifdef FETCH_INST_BUFFER_BYPASS_EN
  logic                   byp;
  logic [FETCH_WIDTH-1:0] byp_vld;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_byp
    localparam logic [CW-1:0] KC = CW'(k);
    assign byp_vld[k] = i_fetch_cnt > KC;
  end

  // A stalled backend cannot take the packet now, so it is queued instead.
  assign byp   = enq && (count == '0) && !i_stall;
  assign wr_en = enq && !byp;

  always_comb begin
    o_inst     = arr_inst;
    o_inst_vld = i_squash_vld ? '0 : arr_vld;
    if (byp) begin
      o_inst     = i_fetch_inst;
      o_inst_vld = byp_vld;
    end
  end
`else
  assign wr_en = enq;

  always_comb begin
    o_inst     = arr_inst;
    o_inst_vld = i_squash_vld ? '0 : arr_vld;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
        if (CW'(k) < i_fetch_cnt) begin
          mem[wptr[AW-1:0] + AW'(k)] <= i_fetch_inst[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_squash_vld) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(i_fetch_cnt);
      // Backend consumes the whole presented window; arr_vld is empty on bypass.
      if (deq)   rptr <= rptr + PW'(popcount(arr_vld));
    end
  end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Scoreboard bench for fetch_inst_buffer; follows FETCH_INST_BUFFER_BYPASS_EN.
module tb_fetch_inst_buffer;
  import fetch_inst_buffer_pkg::*;

  localparam int unsigned FW    = 4;
  localparam int unsigned DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_fetch_vld;
  logic [2:0]           i_fetch_cnt;
  fetchEntry_t [FW-1:0] i_fetch_inst;
  logic                 o_fetch_ready;
  logic [FW-1:0]        o_inst_vld;
  fetchEntry_t [FW-1:0] o_inst;
  logic                 i_stall;
  logic                 i_squash_vld;

  fetchEntry_t  q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int unsigned  seq     = 0;

  always #5 clk = ~clk;

  fetch_inst_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_fetch_vld   (i_fetch_vld),
    .i_fetch_cnt   (i_fetch_cnt),
    .i_fetch_inst  (i_fetch_inst),
    .o_fetch_ready (o_fetch_ready),
    .o_inst_vld    (o_inst_vld),
    .o_inst        (o_inst),
    .i_stall       (i_stall),
    .i_squash_vld  (i_squash_vld)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mask_of(input int unsigned n);
    logic [FW-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < FW; k++) m[k] = (k < n);
    return m;
  endfunction

  // Called just after a rising edge; checks outputs at the falling edge.
  task automatic cyc(input bit fv, input int unsigned cnt, input bit stall, input bit sq);
    fetchEntry_t   pkt [FW];
    bit            exp_ready, enq, byp;
    logic [FW-1:0] exp_vld;
    int unsigned   n;
    for (int unsigned k = 0; k < FW; k++) begin
      pkt[k].pc         = 32'h1000 + 4 * (seq + k);
      pkt[k].inst       = 32'hC0DE_0000 ^ (seq + k);
      pkt[k].pred_taken = ((seq + k) % 3) == 0;
      i_fetch_inst[k]   = pkt[k];
    end
    seq          += FW;
    i_fetch_vld   = fv;
    i_fetch_cnt   = 3'(cnt);
    i_stall       = stall;
    i_squash_vld  = sq;
    #4;
    exp_ready = (DEPTH - q.size()) >= FW;
    enq       = fv && exp_ready && !sq;
`ifdef FETCH_INST_BUFFER_BYPASS_EN
    byp = enq && (q.size() == 0) && !stall;
`else
    byp = 1'b0;
`endif
    n = (q.size() < FW) ? q.size() : FW;
    if (sq)       exp_vld = '0;
    else if (byp) exp_vld = mask_of(cnt);
    else          exp_vld = mask_of(n);
    check_eq("ready", o_fetch_ready, exp_ready);
    check_eq("vld", o_inst_vld, exp_vld);
    for (int unsigned k = 0; k < FW; k++) begin
      if (exp_vld[k]) check_eq($sformatf("inst%0d", k), o_inst[k], byp ? pkt[k] : q[k]);
    end
    if (sq) begin
      q.delete();
    end else begin
      if (!stall && !byp) repeat (n) void'(q.pop_front());
      if (enq && !byp) for (int unsigned k = 0; k < cnt; k++) q.push_back(pkt[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned cycles, input bit stall);
    repeat (cycles) cyc(1'b0, 0, stall, 1'b0);
  endtask

  task automatic do_reset(input int unsigned cycles);
    i_fetch_vld  = 1'b0;
    i_stall      = 1'b0;
    i_squash_vld = 1'b0;
    #2;
    rst = 1'b0;
    repeat (cycles) begin
      #1;
      check_eq("rst_vld", o_inst_vld, '0);
      check_eq("rst_ready", o_fetch_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    q.delete();
  endtask

  initial begin
    rst          = 1'b0;
    i_fetch_vld  = 1'b0;
    i_fetch_cnt  = '0;
    i_fetch_inst = '0;
    i_stall      = 1'b0;
    i_squash_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_vld", o_inst_vld, '0);
    check_eq("reset_ready", o_fetch_ready, 1'b1);
    rst = 1'b1;
    idle(1, 1'b0);

    // Fill to full under stall; fifth packet must be refused.
    repeat (4) cyc(1'b1, 4, 1'b1, 1'b0);
    cyc(1'b1, 4, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    // Offset pointers, then partial packets across the wrap point.
    cyc(1'b1, 2, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Stall hold: output window must not move for five cycles.
    cyc(1'b1, 4, 1'b1, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);

    // Squash with a concurrent packet and dequeue.
    cyc(1'b1, 4, 1'b1, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b1);
    idle(1, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Empty buffer latency, without and with stall.
    cyc(1'b1, 2, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Reset mid-traffic with 8 entries buffered.
    cyc(1'b1, 4, 1'b1, 1'b0);
    cyc(1'b1, 4, 1'b1, 1'b0);
    do_reset(3);
    cyc(1'b1, 4, 1'b0, 1'b0);
    idle(2, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(1, FW),
          $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end
    idle(6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_inst_buffer.md
# fetch_inst_buffer

- Decoupling queue between the fetch stage and the backend's instruction input.
- Accepts up to FETCH_WIDTH fetched instructions per cycle and presents the oldest up to FETCH_WIDTH instructions to the backend.
- Holds them while the backend asserts stall; flushes everything on a backend squash.
- Keeps fetch running during short rename/dispatch stalls.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two, at least 2*FETCH_WIDTH.
- FETCH_WIDTH, `FETCH_WIDTH, instructions per fetch packet and per backend delivery.

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_fetch_vld  in  1  fetch packet present.
- i_fetch_cnt  in  $clog2(FETCH_WIDTH)+1  valid instructions in the packet, 1..FETCH_WIDTH, occupying slots [0..cnt-1].
- i_fetch_inst  in  fetchEntry_t[FETCH_WIDTH]  packet payload.
- o_fetch_ready  out  1  buffer can accept a full packet this cycle.
- o_inst_vld  out  FETCH_WIDTH  contiguous-from-bit-0 valid mask to backend.
- o_inst  out  fetchEntry_t[FETCH_WIDTH]  oldest entries, slot 0 oldest.
- i_stall  in  1  backend refuses delivery this cycle.
- i_squash_vld  in  1  backend squash; flush all contents.

## Operation
- Storage is a circular array of DEPTH fetchEntry_t.
- Pointers: wptr and rptr, each $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit. count = wptr - rptr.
- Full when count == DEPTH; empty when count == 0.

Enqueue:
- Occurs when i_fetch_vld && o_fetch_ready && !i_squash_vld.
- Slot k is written to array[(wptr+k) mod DEPTH] for k < i_fetch_cnt.
- wptr advances by i_fetch_cnt.
- o_fetch_ready = (DEPTH - count) >= FETCH_WIDTH, using the registered count (before this cycle's dequeue). This is deliberately conservative.

Presentation:
- o_inst[k] = array[(rptr+k) mod DEPTH].
- o_inst_vld = low min(count, FETCH_WIDTH) bits set.
- o_inst_vld is forced to 0 while i_squash_vld is asserted.

Dequeue:
- Occurs when !i_stall && !i_squash_vld.
- rptr advances by popcount(o_inst_vld). All presented entries are consumed; there is no partial acceptance.

Simultaneous events:
- Enqueue and dequeue in the same cycle: both pointer updates apply.
- Wrap-around at DEPTH is handled by the modulo index. The wrap bit distinguishes full from empty.

Squash:
- i_squash_vld has priority over enqueue and dequeue.
- Next cycle: wptr = rptr = 0, count = 0.
- Array contents are don't-care and are not cleared.

Reset:
- Asserting rst at any time, including mid-operation, clears wptr and rptr.
- Outputs during and after reset: o_inst_vld = 0, o_fetch_ready = 1. o_inst is don't-care.

## Timing
- Without bypass: an instruction enqueued in cycle N appears on o_inst in cycle N+1 at the earliest. Delivery is registered-state only; there is no combinational path from i_fetch_* to o_inst*.
- o_fetch_ready depends only on registered state; there is no path from i_stall or i_squash_vld to it.
- o_inst_vld depends combinationally on i_squash_vld (masking only).
- Squash in cycle N: o_inst_vld = 0 in N; the first post-squash packet may be enqueued in N+1 and delivered in N+2.
- Throughput: FETCH_WIDTH instructions per cycle sustained when i_fetch_cnt = FETCH_WIDTH and no stall.

## Configuration
- Macro: FETCH_INST_BUFFER_BYPASS_EN.
- Defined:
  - Applies when count == 0, !i_stall, !i_squash_vld and an enqueue occurs.
  - The incoming packet drives o_inst/o_inst_vld in the same cycle and is not written to the array.
  - wptr and rptr are unchanged.
  - If i_stall is asserted, the packet is enqueued normally.
  - Zero-latency delivery.
- Undefined: no bypass; one-cycle minimum latency; no combinational i_fetch_* → o_inst* path.

## Structure
- Shared backend package: fetchEntry_t (existing), FETCH_WIDTH (existing), FIB_DEPTH default constant, and a popcount function for vld masks.
- Single module; no sub-module required.
- The read-window mux is a generate loop inside the module.

## Test plan
- Reset mid-traffic: hold rst low with 8 entries buffered → o_inst_vld = 0 and o_fetch_ready = 1 during and after reset; first new packet delivered 1 cycle after enqueue (no bypass).
- Fill to full: FETCH_WIDTH=4, DEPTH=16, stall held, four packets of cnt=4 → o_fetch_ready drops after the 4th enqueue; the 5th packet is not accepted; release stall → oldest 4 delivered in order, o_fetch_ready = 1 next cycle.
- Partial packets and wrap: packets of cnt 3,1,2,4,3,3 across pointer wrap with no stall → delivered sequence order preserved; o_inst_vld = 4'b0111, then contiguous masks matching buffered count.
- Squash with simultaneous enqueue and dequeue: 6 entries buffered, i_fetch_vld=1, i_stall=0, i_squash_vld=1 → o_inst_vld = 0 that cycle; count = 0 next cycle; the squash-cycle packet is discarded.
- Stall hold: i_stall=1 for 5 cycles with 4 entries buffered → o_inst and o_inst_vld stable across all 5 cycles; entries delivered exactly once on release.
- Bypass (macro defined): empty buffer, no stall, packet cnt=2 → o_inst_vld = 4'b0011 in the same cycle and count remains 0; repeat with i_stall=1 → delivered the next cycle after stall drops.
